// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with memory handshake, per-state stall timeout and illegal-opcode trap.
// Optional ORI path enabled by defining MULTICYCLE_CTRL_ORI_EN.
module multicycle_ctrl #(
  parameter int MEM_HS     = 1,
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       branch,
  output logic       irwrite,
  output logic       iord,
  output logic       memen,
  output logic       memwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [1:0] alu_op,
  output logic       mem_timeout,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTEXE   = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEXE = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ORIEXE  = 4'd12
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ORI_EN
  localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

  localparam int            CW    = $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            rdy;
  logic            mem_state;
  logic            timeout;
  logic            bad_op;

  assign rdy       = (MEM_HS != 0) ? mem_ready : 1'b1;
  assign mem_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
  assign timeout   = mem_state && !rdy && (wait_q == LIMIT);

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d = FETCH;
    bad_op  = 1'b0;
    case (state_q)
      FETCH:   state_d = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTEXE;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXE;
          OP_J:         state_d = JUMP;
`ifdef MULTICYCLE_CTRL_ORI_EN
          OP_ORI:       state_d = ORIEXE;
`endif
          default: begin
            state_d = FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      MEMADR:  state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (rdy)          state_d = MEMWB;
        else if (timeout) state_d = FETCH;
        else              state_d = MEMRD;
      end
      MEMWB:   state_d = FETCH;
      MEMWR:   state_d = (rdy || timeout) ? FETCH : MEMWR;
      RTEXE:   state_d = ALUWB;
      ALUWB:   state_d = FETCH;
      BRANCH:  state_d = FETCH;
      ADDIEXE: state_d = IMMWB;
      IMMWB:   state_d = FETCH;
      JUMP:    state_d = FETCH;
`ifdef MULTICYCLE_CTRL_ORI_EN
      ORIEXE:  state_d = IMMWB;
`endif
      default: state_d = FETCH;
    endcase
  end

  // The stall counter only advances below the limit, so it can never wrap;
  // a FETCH timeout stays in FETCH and must still restart the count.
  always_comb begin
    wait_d = '0;
    if (mem_state && !rdy && !timeout && (state_d == state_q))
      wait_d = wait_q + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign state = state_q;

  // NOTE: outputs are forced low combinationally while rst_n is low, so an
  // access in flight is dropped in the same cycle the reset arrives.
  always_comb begin
    pcwrite     = 1'b0;
    branch      = 1'b0;
    irwrite     = 1'b0;
    iord        = 1'b0;
    memen       = 1'b0;
    memwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    pcsrc       = 2'b00;
    alu_op      = 2'b00;
    mem_timeout = 1'b0;
    illegal     = 1'b0;
    if (rst_n) begin
      mem_timeout = timeout;
      illegal     = bad_op;
      case (state_q)
        FETCH: begin
          memen   = 1'b1;
          alusrcb = 2'b01;
          pcwrite = rdy;
          irwrite = rdy;
        end
        MEMADR: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        MEMRD: begin
          iord  = 1'b1;
          memen = 1'b1;
        end
        MEMWB: begin
          memtoreg = 1'b1;
          regwrite = 1'b1;
        end
        MEMWR: begin
          iord     = 1'b1;
          memen    = 1'b1;
          memwrite = 1'b1;
        end
        RTEXE: begin
          alusrca = 1'b1;
          alu_op  = 2'b10;
        end
        ALUWB: begin
          regdst   = 1'b1;
          regwrite = 1'b1;
        end
        BRANCH: begin
          alusrca = 1'b1;
          alu_op  = 2'b01;
          branch  = 1'b1;
          pcsrc   = 2'b01;
        end
        ADDIEXE: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
        end
        IMMWB:   regwrite = 1'b1;
        JUMP: begin
          pcsrc   = 2'b10;
          pcwrite = 1'b1;
        end
`ifdef MULTICYCLE_CTRL_ORI_EN
        ORIEXE: begin
          alusrca = 1'b1;
          alusrcb = 2'b10;
          alu_op  = 2'b11;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_HS, default 1: 1 = honour mem_ready; 0 = treat mem_ready as constant 1.
REQ-002 SHALL have parameter WAIT_LIMIT, default 15: max stall cycles per memory state (1..255).
REQ-003 SHALL have ports, in this order:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  instruction-register opcode, valid from DECODE onward
- mem_ready  in  1  memory access complete this cycle
- pcwrite  out  1  PC load enable
- branch  out  1  conditional PC load (qualified by zero outside)
- irwrite  out  1  instruction-register load
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memen  out  1  memory access request
- memwrite  out  1  store strobe
- regdst  out  1  destination select: 1 = rd
- memtoreg  out  1  write-back select: 1 = MDR
- regwrite  out  1  register-file write
- alusrca  out  1  ALU A select: 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sign-imm, 11 = imm<<2
- pcsrc  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  00 = add, 01 = sub, 10 = funct, 11 = or
- mem_timeout  out  1  one-cycle pulse on abandoned access
- illegal  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state, for debug

Function
REQ-004 SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXE=6, ALUWB=7, BRANCH=8, ADDIEXE=9, IMMWB=10, JUMP=11, ORIEXE=12. Codes 13-15 SHALL go to FETCH.
REQ-005 Outputs not listed for a state SHALL be 0. In FETCH: memen=1, alusrcb=01, and pcwrite = irwrite = mem_ready (the only Mealy-qualified outputs).
REQ-006 Transitions:
- FETCH -> DECODE when mem_ready.
- DECODE dispatches on opcode: 100011/101011 -> MEMADR; 000000 -> RTEXE; 000100 -> BRANCH; 001000 -> ADDIEXE; 000010 -> JUMP.
- DECODE with any other opcode -> FETCH, pulsing illegal.
REQ-007 MEMADR: alusrca=1, alusrcb=10. Next state is MEMRD if opcode is 100011, otherwise MEMWR.
REQ-008 MEMRD: iord=1, memen=1; goes to MEMWB on mem_ready. MEMWB: memtoreg=1, regwrite=1; goes to FETCH.
REQ-009 MEMWR: iord=1, memen=1, memwrite=1; goes to FETCH on mem_ready.
REQ-010 R-type path:
- RTEXE: alusrca=1, alu_op=10; goes to ALUWB.
- ALUWB: regdst=1, regwrite=1; goes to FETCH.
REQ-011 BRANCH: alusrca=1, alu_op=01, branch=1, pcsrc=01; goes to FETCH.
REQ-012 Immediate and jump paths:
- ADDIEXE: alusrca=1, alusrcb=10; goes to IMMWB.
- IMMWB: regwrite=1; goes to FETCH.
- JUMP: pcsrc=10, pcwrite=1; goes to FETCH.
REQ-013 Wait counter:
- SHALL count consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0.
- SHALL clear on state change or on mem_ready.
- SHALL be $clog2(WAIT_LIMIT+1) bits wide and SHALL never wrap.
REQ-014 When the wait counter equals WAIT_LIMIT and mem_ready=0, the FSM SHALL pulse mem_timeout and go to FETCH. A FETCH timeout restarts FETCH with no pcwrite.
REQ-015 mem_ready=1 in the same cycle as the limit SHALL win: normal transition, no timeout.
REQ-016 mem_ready SHALL be ignored in non-memory states.

Reset
REQ-017 While rst_n=0: state=FETCH, wait counter=0, and every output (including pulses) SHALL be 0. state reads 0.
REQ-018 Reset assertion mid-access SHALL abandon the access immediately. The first cycle after release SHALL be FETCH, with outputs per REQ-005.

Configuration
REQ-019 Macro MULTICYCLE_CTRL_ORI_EN:
- Defined: DECODE sends opcode 001101 to ORIEXE (alusrca=1, alusrcb=10, alu_op=11), which goes to IMMWB.
- Undefined: 001101 is illegal per REQ-006, and ORIEXE is unreachable (treated as code 13-15).

Verification
REQ-020 lw (opcode 100011), mem_ready high from FETCH onward -> state sequence 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-021 sw (opcode 101011), mem_ready held low 3 cycles in MEMWR -> memwrite=1 for 4 cycles, then FETCH; mem_timeout stays 0.
REQ-022 WAIT_LIMIT=15, mem_ready=0 in MEMRD -> mem_timeout pulses in the 16th MEMRD cycle; next state is FETCH; regwrite never asserts.
REQ-023 opcode 111111 at DECODE -> illegal pulses once; state returns to 0; no write strobe asserts.
REQ-024 opcode 001101, with and without MULTICYCLE_CTRL_ORI_EN:
- With: states 0,1,12,10,0, and alu_op=11 in state 12.
- Without: illegal pulses.
REQ-025 rst_n low during MEMWR with mem_ready=0 -> all outputs 0 in the same cycle; after release, state=0 and memen=1.
